alu_seq: RTL and testbench

Parametrised, handshaked successor to the 32-bit combinational ALU. It adds set-less-than and shift operations, plus multi-cycle unsigned multiply, divide and remainder, all at a configurable datapath width. Operands enter through a valid/ready input port. Results and flags leave through a registered valid/ready output port. The block sits between the register-read stage and write-back of the processor datapath, and stalls upstream while an iterative operation runs.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_seq_if.sv | 29 ++
 rtl/muldiv_iter.sv | 80 ++++++++
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state type and op classification for the sequenced ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the datapath stages and the ALU.
interface alu_seq_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero;
    logic         overflow;
    logic         carry;
    logic         div0;
    logic         illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, zero, overflow, carry, div0, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, zero, overflow, carry, div0, illegal
    );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative engine: shift-add multiply and restoring divide, one bit per cycle.
module muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         m_clock,
    input  logic         p_reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         div0
);
    localparam int unsigned CW = $clog2(W);

    logic          busy_q, is_mul_q, is_rem_q, div0_q;
    logic [CW-1:0] cnt_q;
    // acc: product or partial remainder; opa: multiplicand or dividend/quotient;
    // opb: multiplier (shifted) or divisor (fixed).
    logic [W-1:0]  acc_q, opa_q, opb_q;
    logic [W-1:0]  acc_n, opa_n, opb_n;
    logic [W:0]    rem_sh, rem_diff;

    always_comb begin
        acc_n    = acc_q;
        opa_n    = opa_q;
        opb_n    = opb_q;
        rem_sh   = {acc_q, opa_q[W-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        if (is_mul_q) begin
            acc_n = acc_q + (opb_q[0] ? opa_q : '0);
            opa_n = opa_q << 1;
            opb_n = opb_q >> 1;
        end else begin
            // Restore when the trial subtraction goes negative.
            acc_n = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
            opa_n = {opa_q[W-2:0], ~rem_diff[W]};
        end
    end

    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == CW'(W - 1));
    assign result = (is_mul_q || is_rem_q) ? acc_n : opa_n;
    assign div0   = div0_q;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            busy_q   <= 1'b0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            is_mul_q <= (op == OP_MULU);
            is_rem_q <= (op == OP_REMU);
            div0_q   <= (op != OP_MULU) && (b == '0);
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= a;
            opb_q    <= b;
        end else if (busy_q) begin
            acc_q <= acc_n;
            opa_q <= opa_n;
            opb_q <= opb_n;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative MULU/DIVU/REMU,
// with a registered result and flag stage.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic     m_clock,
    input  logic     p_reset,
    alu_seq_if.slave bus
);
    localparam int unsigned SW = $clog2(W);

    state_e        state_q, state_d;
    logic          accept, multi, eng_start;
    logic [W:0]    sum, diff;
    logic [SW-1:0] shamt;
    logic [W-1:0]  res;
    logic          ovf, cy, ill;
    logic          eng_busy, eng_done, eng_div0;
    logic [W-1:0]  eng_result;
    logic [W-1:0]  out_q;
    logic          zero_q, ovf_q, cy_q, div0_q, ill_q;

    assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign multi        = is_multicycle(bus.op);
    assign eng_start    = accept && multi;

    assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
    assign shamt = bus.b[SW-1:0];

    always_comb begin
        res = '0;
        ovf = 1'b0;
        cy  = 1'b0;
        ill = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res = sum[W-1:0];
                cy  = sum[W];
                ovf = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                res = diff[W-1:0];
                cy  = ~diff[W];
                ovf = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
            end
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_NOR:  res = ~(bus.a | bus.b);
            OP_SLT:  res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: res = {{(W-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  res = bus.a << shamt;
            OP_SRL:  res = bus.a >> shamt;
            OP_SRA:  res = $signed(bus.a) >>> shamt;
            OP_MULU, OP_DIVU, OP_REMU: res = '0;
            default: ill = 1'b1;
        endcase
    end

    muldiv_iter #(
        .W(W)
    ) u_muldiv (
        .m_clock(m_clock),
        .p_reset(p_reset),
        .start  (eng_start),
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .busy   (eng_busy),
        .done   (eng_done),
        .result (eng_result),
        .div0   (eng_div0)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = multi ? S_BUSY : S_DONE;
                end else if (state_q == S_DONE && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (eng_done) begin
                    state_d = S_DONE;
                end else if (!eng_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cy_q    <= 1'b0;
            div0_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !multi) begin
                out_q  <= res;
                zero_q <= (res == '0) && !ill;
                ovf_q  <= ovf;
                cy_q   <= cy;
                div0_q <= 1'b0;
                ill_q  <= ill;
            end else if (eng_done) begin
                out_q  <= eng_result;
                zero_q <= (eng_result == '0);
                ovf_q  <= 1'b0;
                cy_q   <= 1'b0;
                div0_q <= eng_div0;
                ill_q  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry     = cy_q;
    assign bus.div0      = div0_q;
    assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random ops against an arithmetic reference model,
// plus handshake stall, streaming and mid-operation reset scenarios.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned W = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic [W-1:0] out;
        logic         zero;
        logic         overflow;
        logic         carry;
        logic         div0;
        logic         illegal;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) dut (
        .m_clock(clk),
        .p_reset(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_model(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        res_t        r;
        longint      sa, sb, s;
        logic [63:0] wide;
        int unsigned sh;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b % 32;
        case (op)
            OP_ADD: begin
                wide = {32'd0, a} + {32'd0, b};
                r.out = wide[31:0];
                r.carry = wide[32];
                s = sa + sb;
                r.overflow = (s > SMAX) || (s < SMIN);
            end
            OP_SUB: begin
                r.out = a - b;
                r.carry = (a >= b);
                s = sa - sb;
                r.overflow = (s > SMAX) || (s < SMIN);
            end
            OP_AND:  r.out = a & b;
            OP_OR:   r.out = a | b;
            OP_XOR:  r.out = a ^ b;
            OP_NOR:  r.out = ~(a | b);
            OP_SLT:  r.out = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: r.out = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  r.out = a << sh;
            OP_SRL:  r.out = a >> sh;
            OP_SRA:  begin s = sa >>> sh; r.out = s[31:0]; end
            OP_MULU: begin wide = {32'd0, a} * {32'd0, b}; r.out = wide[31:0]; end
            OP_DIVU: begin
                if (b == 0) begin r.out = '1; r.div0 = 1'b1; end
                else r.out = a / b;
            end
            OP_REMU: begin
                if (b == 0) begin r.out = a; r.div0 = 1'b1; end
                else r.out = a % b;
            end
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.out == 0) && !r.illegal;
        return r;
    endfunction

    function automatic res_t observe();
        res_t r;
        r.out = bus.out;
        r.zero = bus.zero;
        r.overflow = bus.overflow;
        r.carry = bus.carry;
        r.div0 = bus.div0;
        r.illegal = bus.illegal;
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("out=%h z=%b v=%b c=%b d0=%b ill=%b", r.out, r.zero, r.overflow,
                         r.carry, r.div0, r.illegal);
    endfunction

    // Issue one op with out_ready low, scramble inputs after accept, wait for the result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output res_t got, output int lat, output bit busy_ready);
        int guard = 0;
        busy_ready = 1'b0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, want 1",
                     bus.in_ready, guard);
        end
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) busy_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        got = observe();
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (observe() !== res_t'(0)) begin
            errors++; $display("FAIL reset_outputs: got %s want all zero", fmt(observe()));
        end
    endtask

    task automatic test_directed();
        logic [3:0]  vop [14];
        logic [31:0] va [14];
        logic [31:0] vb [14];
        logic [31:0] vout [14];
        res_t got, exp;
        int   lat, want_lat;
        bit   br;
        vop  = '{OP_ADD, OP_SUB, OP_SUB, OP_SRA, OP_SLT, OP_SLTU, OP_MULU, OP_DIVU,
                 OP_REMU, OP_DIVU, 4'd15, 4'd14, OP_SLL, OP_NOR};
        va   = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h10001, 32'd100, 32'd100, 32'd9, 32'h12345678, 32'd0, 32'd1, 32'd0};
        vb   = '{32'd1, 32'd5, 32'd1, 32'h24, 32'd1, 32'd1, 32'h10001, 32'd7, 32'd7,
                 32'd0, 32'd1, 32'd0, 32'h3F, 32'd0};
        vout = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hF8000000, 32'd1, 32'd0,
                 32'h00020001, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h80000000,
                 32'hFFFFFFFF};
        for (int i = 0; i < 14; i++) begin
            do_op(vop[i], va[i], vb[i], got, lat, br);
            exp = ref_model(vop[i], va[i], vb[i]);
            want_lat = is_multicycle(vop[i]) ? W + 1 : 1;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL directed_%0d op=%0d: got %s want %s", i, vop[i], fmt(got),
                         fmt(exp));
            end
            checks++;
            if (got.out !== vout[i]) begin
                errors++;
                $display("FAIL directed_out_%0d: got %h want %h", i, got.out, vout[i]);
            end
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL directed_latency_%0d: got %0d want %0d", i, lat, want_lat);
            end
            checks++;
            if (br) begin
                errors++;
                $display("FAIL directed_busy_ready_%0d: in_ready seen 1 while busy, want 0", i);
            end
            drain();
        end
    endtask

    task automatic test_stall();
        res_t held, got, exp;
        int   lat;
        bit   br;
        logic [31:0] na, nb;
        do_op(OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_1234, held, lat, br);
        na = $urandom;
        nb = $urandom;
        bus.in_valid = 1'b1;
        bus.op = OP_SUB;
        bus.a = na;
        bus.b = nb;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready_%0d: got %b want 0", i, bus.in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || observe() !== held) begin
                errors++;
                $display("FAIL stall_hold_%0d: got v=%b %s want v=1 %s", i, bus.out_valid,
                         fmt(observe()), fmt(held));
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        got = observe();
        exp = ref_model(OP_SUB, na, nb);
        checks++;
        if (bus.out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL stall_same_cycle_accept: got v=%b %s want v=1 %s", bus.out_valid,
                     fmt(got), fmt(exp));
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] xa [8];
        logic [31:0] xb [8];
        res_t got, exp;
        for (int i = 0; i < 8; i++) begin
            xa[i] = $urandom;
            xb[i] = $urandom;
        end
        bus.op = OP_ADD;
        bus.a = xa[0];
        bus.b = xb[0];
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            got = observe();
            exp = ref_model(OP_ADD, xa[i], xb[i]);
            if (i < 7) begin
                bus.a = xa[i+1];
                bus.b = xb[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            checks++;
            if (bus.out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b %s want v=1 %s", i, bus.out_valid,
                         fmt(got), fmt(exp));
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_end_valid: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        res_t got, exp;
        int   lat;
        bit   br;
        logic [31:0] ma, mb;
        bus.in_valid = 1'b1;
        bus.op = OP_MULU;
        bus.a = $urandom;
        bus.b = $urandom;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_abort: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid,
                     bus.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_no_result: got v=%b want 0", bus.out_valid);
        end
        ma = $urandom;
        mb = $urandom;
        do_op(OP_MULU, ma, mb, got, lat, br);
        exp = ref_model(OP_MULU, ma, mb);
        checks++;
        if (got !== exp || lat != W + 1) begin
            errors++;
            $display("FAIL reset_mid_next_op: got %s lat=%0d want %s lat=%0d", fmt(got), lat,
                     fmt(exp), W + 1);
        end
        drain();
    endtask

    task automatic test_random();
        res_t got, exp;
        int   lat, want_lat;
        bit   br;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(0, 3);
                1:       rb = $urandom_range(0, 300);
                default: rb = $urandom;
            endcase
            do_op(op, ra, rb, got, lat, br);
            exp = ref_model(op, ra, rb);
            want_lat = is_multicycle(op) ? W + 1 : 1;
            checks++;
            if (got !== exp || lat != want_lat) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %s lat=%0d want %s lat=%0d", i,
                         op, ra, rb, fmt(got), lat, fmt(exp), want_lat);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            drain();
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
